graphics_reg_bank: RTL
======================

Name: graphics_reg_bank

Overview:
- Upstream stage of the graphics ASIC, between the CPU memory bus and the sprite/score renderers.
- Captures CPU writes (chipselect/databus/data_address) into a shadow register set, range-clamping each value on entry.
- On CPU commit, swaps shadow into active registers at the next frame boundary, so renderers never see a half-updated scene (tear-free double buffering).
- Active registers drive the renderers' x_loc/y_loc/z_loc/score/game_state inputs directly.

Parameters:
- CS_CODE, 4'b0100, chipselect value selecting this block
- X_MAX, 16'd639, maximum legal x coordinate
- Y_MAX, 16'd479, maximum legal y coordinate
- Z_MAX, 16'd999, maximum legal ball depth

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low (rst==0 resets on the clock edge)
- chipselect  input  4  bus chip select; a write occurs every cycle chipselect==CS_CODE
- databus  input  16  write data
- data_address  input  4  register index
- frame_done  input  1  one-cycle pulse: last pixel of frame accepted by VGA (VGA_ready && pixel_address==19'h4AFFF)
- paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y  output  16 each  active paddle positions
- ball_x, ball_y, ball_z  output  16 each  active ball position
- player_1_score, player_2_score  output  16 each  active scores
- game_state  output  16  active game state word
- commit_pending  output  1  commit armed, swap awaiting frame_done
- frame_count  output  16  number of swaps performed, wraps 16'hFFFF->0
- bad_addr  output  1  sticky: write to reserved address seen

Behaviour:
- Address map: 0 p1_x, 1 p1_y, 2 p2_x, 3 p2_y, 4 ball_x, 5 ball_y, 6 ball_z, 7 p1_score, 8 p2_score, 9 game_state, 10–14 reserved, 15 COMMIT (data ignored).
- Reset (rst==0), both shadow and active sets:
  - p1_x=100, p1_y=200, p2_x=350, p2_y=250
  - ball_x=320, ball_y=240, ball_z=0
  - scores=0, game_state=0
  - commit_pending=0, frame_count=0, bad_addr=0
- Reset mid-frame or mid-commit discards pending data and returns every register to its reset value.
- Write (chipselect==CS_CODE, addr 0–9): shadow register updated next edge. Clamping (unsigned compare):
  - x registers: min(data, X_MAX)
  - y registers: min(data, Y_MAX)
  - ball_z: min(data, Z_MAX)
  - scores and game_state: unclamped
- Write to addr 10–14: no register change; bad_addr set, held until reset.
- chipselect != CS_CODE: bus ignored entirely.
- State machine, 2 states:
  - IDLE (commit_pending=0): COMMIT write -> ARMED next edge.
  - ARMED (commit_pending=1): frame_done -> every active register loads its shadow register in that single edge; frame_count+1; go IDLE.
  - ARMED: COMMIT write while already armed -> no effect.
  - Shadow writes stay legal in ARMED; writes landing before the swap edge are included in the swap.
- frame_done in IDLE: no swap, frame_count unchanged.
- Same-edge events:
  - Shadow write + swap: active takes the pre-write shadow value; shadow takes the new value, which waits for a later commit.
  - COMMIT write + frame_done in ARMED: swap happens; next state is ARMED (new commit applies to the following frame).
  - COMMIT write + frame_done in IDLE: no swap; next state ARMED.
- Latency: write to visible active output = swap edge; outputs change only on a swap edge or reset; all outputs registered.

Test Plan:
- Reset: hold rst=0 two cycles -> p1_x=100, p2_y=250, ball_x=320, ball_z=0, commit_pending=0, frame_count=0, bad_addr=0.
- Write addr0=16'd500, addr6=16'd1200, commit, pulse frame_done -> paddle_1_x=500, ball_z=999, frame_count=1, commit_pending=0; before the pulse, active outputs still at reset values.
- Write addr4=16'd700 with no commit, pulse frame_done three times -> ball_x stays 320, frame_count=0; then commit + frame_done -> ball_x=639.
- Commit, then write addr7=5 in the same cycle as frame_done -> player_1_score=0 after that swap; second commit + frame_done -> 5, frame_count=2.
- COMMIT write coincident with frame_done while ARMED -> frame_count+1, commit_pending still 1; next frame_done -> frame_count+1 again, pending cleared.
- Write addr12 -> bad_addr=1, no register changes; chipselect=4'b0001 with addr0=9 -> ignored. Drop rst low while ARMED -> all values back to reset, bad_addr=0.

Source files
------------

// File: rtl/graphics_reg_bank.sv
// graphics_reg_bank
// -----------------
// Double-buffered register bank between the CPU memory bus and the
// sprite/score renderers.
//
// The CPU writes go into a shadow register set. Coordinates are clamped to the
// visible area and the ball depth is clamped to its legal range as they arrive.
// A write to the COMMIT address arms a swap. On the next frame_done pulse,
// every active register loads its shadow copy on the same edge. The renderers
// therefore never see a scene that is only partly updated.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active-low
//   chipselect     bus chip select; the bus is live when it equals CS_CODE
//   databus        16-bit write data
//   data_address   register index (0-9 data, 10-14 reserved, 15 COMMIT)
//   frame_done     one-cycle pulse at the last accepted pixel of a frame
//   paddle_*/ball_*/player_*_score/game_state   active register outputs
//   commit_pending swap armed, waiting for frame_done
//   frame_count    number of swaps performed (wraps)
//   bad_addr       sticky flag: a reserved address was written

module graphics_reg_bank #(
  parameter logic [3:0]  CS_CODE = 4'b0100,
  parameter logic [15:0] X_MAX   = 16'd639,
  parameter logic [15:0] Y_MAX   = 16'd479,
  parameter logic [15:0] Z_MAX   = 16'd999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  chipselect,
  input  logic [15:0] databus,
  input  logic [3:0]  data_address,
  input  logic        frame_done,
  output logic [15:0] paddle_1_x,
  output logic [15:0] paddle_1_y,
  output logic [15:0] paddle_2_x,
  output logic [15:0] paddle_2_y,
  output logic [15:0] ball_x,
  output logic [15:0] ball_y,
  output logic [15:0] ball_z,
  output logic [15:0] player_1_score,
  output logic [15:0] player_2_score,
  output logic [15:0] game_state,
  output logic        commit_pending,
  output logic [15:0] frame_count,
  output logic        bad_addr
);

  localparam int         NUM_REGS    = 10;
  localparam logic [3:0] COMMIT_ADDR = 4'd15;

  // Reset value for each register index.
  function automatic logic [15:0] reset_value(input int idx);
    case (idx)
      0:       return 16'd100;
      1:       return 16'd200;
      2:       return 16'd350;
      3:       return 16'd250;
      4:       return 16'd320;
      5:       return 16'd240;
      default: return 16'd0;
    endcase
  endfunction

  // Upper bound for each register index.
  // 16'hFFFF leaves the register effectively unclamped.
  function automatic logic [15:0] clamp_limit(input int idx);
    case (idx)
      0, 2, 4: return X_MAX;
      1, 3, 5: return Y_MAX;
      6:       return Z_MAX;
      default: return 16'hFFFF;
    endcase
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic        bus_write;
  logic        commit_write;
  logic        reserved_write;
  logic        swap;
  logic [15:0] frame_count_reg;
  logic        bad_addr_reg;
  logic [15:0] active_bus [NUM_REGS];

  assign bus_write      = (chipselect == CS_CODE);
  assign commit_write   = bus_write && (data_address == COMMIT_ADDR);
  assign reserved_write = bus_write && (data_address >= 4'd10) &&
                          (data_address <= 4'd14);

  // A swap happens only from ARMED. A COMMIT write on the swap edge re-arms
  // for the following frame instead of being lost.
  assign swap = (state_reg == ARMED) && frame_done;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (commit_write) state_next = ARMED;
      ARMED:   if (frame_done)   state_next = commit_write ? ARMED : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      frame_count_reg <= 16'd0;
      bad_addr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (swap)           frame_count_reg <= frame_count_reg + 16'd1;
      if (reserved_write) bad_addr_reg    <= 1'b1;
    end
  end

  // One shadow/active pair per register index.
  // The swap reads the shadow's current (pre-write) value, so a write that
  // lands on the swap edge is held back for a later commit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [15:0] LIMIT = clamp_limit(gi);
      localparam logic [15:0] RESET = reset_value(gi);

      logic        hit;
      logic [15:0] clamped;
      logic [15:0] shadow_reg;
      logic [15:0] active_reg;

      assign hit     = bus_write && (data_address == 4'(gi));
      assign clamped = (databus > LIMIT) ? LIMIT : databus;

      always_ff @(posedge clk) begin
        if (!rst) begin
          shadow_reg <= RESET;
          active_reg <= RESET;
        end else begin
          if (hit)  shadow_reg <= clamped;
          if (swap) active_reg <= shadow_reg;
        end
      end

      assign active_bus[gi] = active_reg;
    end
  endgenerate

  assign paddle_1_x     = active_bus[0];
  assign paddle_1_y     = active_bus[1];
  assign paddle_2_x     = active_bus[2];
  assign paddle_2_y     = active_bus[3];
  assign ball_x         = active_bus[4];
  assign ball_y         = active_bus[5];
  assign ball_z         = active_bus[6];
  assign player_1_score = active_bus[7];
  assign player_2_score = active_bus[8];
  assign game_state     = active_bus[9];
  assign commit_pending = (state_reg == ARMED);
  assign frame_count    = frame_count_reg;
  assign bad_addr       = bad_addr_reg;

endmodule
